step_seq_ctrl: RTL and testbench

STEP_SEQ_CTRL -- requirements
Module: step_seq_ctrl

---
 rtl/step_seq_ctrl_pkg.sv | 23 ++
 rtl/seg_fifo.sv | 79 +++++++
 rtl/step_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_step_seq_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_seq_ctrl_pkg.sv
// Shared types and constants for the step sequencer controller.
// Holds the FSM encoding, the segment width and the default FIFO depth.
package step_seq_ctrl_pkg;

    localparam int SEG_W     = 64;
    localparam int DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_ABORTED   = 2'd3
    } state_e;

    // A segment is stored as {dt, steps}.
    function automatic logic [SEG_W-1:0] seg_pack(
        input logic [31:0] dt,
        input logic [31:0] steps
    );
        return {dt, steps};
    endfunction

endpackage

// File: rtl/seg_fifo.sv
// Synchronous segment FIFO with registered full/empty flags.
// Ports: clk, reset, flush_i, push_i/wdata_i, pop_i/rdata_o, full_o, empty_o.
module seg_fifo
    import step_seq_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [SEG_W-1:0] wdata_i,
    input  logic             pop_i,
    output logic [SEG_W-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [SEG_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_q && !flush_i;
    assign do_pop  = pop_i && !empty_q && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
        full_d  = (cnt_d == FULL_CNT);
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: entries are only read behind the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/step_seq_ctrl.sv
// Step sequencer controller: queues {dt, steps} segments and feeds them
// to a step generator one at a time, tracking completions and underruns.
// Ports: segment push (seg_*), start/flush, generator buses and strobes
// (gen_*), generator status inputs, and status outputs busy, underrun,
// segs_done, total_steps.
module step_seq_ctrl
    import step_seq_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] seg_dt,
    input  logic [31:0] seg_steps,
    input  logic        seg_valid,
    output logic        seg_ready,
    input  logic        start,
    input  logic        flush,
    input  logic [31:0] abort_dt,
    output logic [31:0] gen_dt_val,
    output logic [31:0] gen_steps_val,
    output logic        gen_load,
    output logic        gen_set_dt_limit,
    output logic        gen_set_steps_limit,
    output logic        gen_reset_dt,
    output logic        gen_reset_steps,
    input  logic        gen_step_stb,
    input  logic        gen_done,
    input  logic        gen_abort,
    output logic        busy,
    output logic        underrun,
    output logic [15:0] segs_done,
    output logic [31:0] total_steps
);

    state_e           state_q, state_d;
    logic             load_q, load_d;
    logic             rdt_q, rdt_d;
    logic [31:0]      dt_q, dt_d;
    logic [31:0]      steps_q, steps_d;
    logic             underrun_q, underrun_d;
    logic [15:0]      segs_q, segs_d;
    logic [31:0]      total_q, total_d;

    logic             pop;
    logic             fifo_flush;
    logic             fifo_full;
    logic             fifo_empty;
    logic [SEG_W-1:0] fifo_rdata;

    seg_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (fifo_flush),
        .push_i  (seg_valid),
        .wdata_i (seg_pack(seg_dt, seg_steps)),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        fifo_flush = 1'b0;
        load_d     = 1'b0;
        rdt_d      = 1'b0;
        underrun_d = underrun_q;
        segs_d     = segs_q;
        total_d    = total_q + {31'd0, gen_step_stb};

        if (flush) begin
            fifo_flush = 1'b1;
            state_d    = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start && !fifo_empty) begin
                        pop        = 1'b1;
                        load_d     = 1'b1;
                        rdt_d      = 1'b1;
                        underrun_d = 1'b0;
                        state_d    = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (gen_done) begin
                        segs_d = segs_q + 16'd1;
                        if (!fifo_empty) begin
                            pop    = 1'b1;
                            load_d = 1'b1;
                        end else begin
                            state_d = ST_WAIT_DATA;
                        end
                    end
                end
                ST_WAIT_DATA: begin
                    // Abort outranks a segment arriving in the same cycle.
                    if (gen_abort) begin
                        underrun_d = 1'b1;
                        state_d    = ST_ABORTED;
                    end else if (!fifo_empty) begin
                        pop     = 1'b1;
                        load_d  = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                ST_ABORTED: begin
                    state_d = ST_ABORTED;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        dt_d    = pop ? fifo_rdata[63:32] : dt_q;
        steps_d = pop ? fifo_rdata[31:0]  : steps_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            load_q     <= 1'b0;
            rdt_q      <= 1'b0;
            dt_q       <= '0;
            steps_q    <= '0;
            underrun_q <= 1'b0;
            segs_q     <= '0;
            total_q    <= '0;
        end else begin
            state_q    <= state_d;
            load_q     <= load_d;
            rdt_q      <= rdt_d;
            dt_q       <= dt_d;
            steps_q    <= steps_d;
            underrun_q <= underrun_d;
            segs_q     <= segs_d;
            total_q    <= total_d;
        end
    end

    assign seg_ready           = !fifo_full;
    assign gen_load            = load_q;
    assign gen_set_dt_limit    = load_q;
    assign gen_set_steps_limit = load_q;
    assign gen_reset_steps     = load_q;
    assign gen_reset_dt        = rdt_q;
    assign gen_dt_val          = (state_q == ST_ABORTED) ? abort_dt : dt_q;
    assign gen_steps_val       = steps_q;
    assign busy                = (state_q != ST_IDLE);
    assign underrun            = underrun_q;
    assign segs_done           = segs_q;
    assign total_steps         = total_q;

endmodule

// File: tb/tb_step_seq_ctrl.sv
// Scoreboard bench for step_seq_ctrl: stimulus queues expected loads,
// a negedge monitor pops and compares every gen_load it observes.
module tb_step_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] seg_dt, seg_steps;
    logic        seg_valid, seg_ready;
    logic        start, flush;
    logic [31:0] abort_dt;
    logic [31:0] gen_dt_val, gen_steps_val;
    logic        gen_load, gen_set_dt_limit, gen_set_steps_limit;
    logic        gen_reset_dt, gen_reset_steps;
    logic        gen_step_stb, gen_done, gen_abort;
    logic        busy, underrun;
    logic [15:0] segs_done;
    logic [31:0] total_steps;

    typedef struct {
        logic [31:0] dt;
        logic [31:0] steps;
        logic        rdt;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_total = 0;

    step_seq_ctrl #(.DEPTH(4)) dut (
        .clk                 (clk),
        .reset               (reset),
        .seg_dt              (seg_dt),
        .seg_steps           (seg_steps),
        .seg_valid           (seg_valid),
        .seg_ready           (seg_ready),
        .start               (start),
        .flush               (flush),
        .abort_dt            (abort_dt),
        .gen_dt_val          (gen_dt_val),
        .gen_steps_val       (gen_steps_val),
        .gen_load            (gen_load),
        .gen_set_dt_limit    (gen_set_dt_limit),
        .gen_set_steps_limit (gen_set_steps_limit),
        .gen_reset_dt        (gen_reset_dt),
        .gen_reset_steps     (gen_reset_steps),
        .gen_step_stb        (gen_step_stb),
        .gen_done            (gen_done),
        .gen_abort           (gen_abort),
        .busy                (busy),
        .underrun            (underrun),
        .segs_done           (segs_done),
        .total_steps         (total_steps)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every load must match the oldest expectation, on its cycle.
    always @(negedge clk) begin
        if (gen_load) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL load_unexpected: got load dt=%0d steps=%0d cyc=%0d, required none",
                         gen_dt_val, gen_steps_val, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (gen_dt_val !== e.dt || gen_steps_val !== e.steps ||
                    gen_reset_dt !== e.rdt || gen_set_dt_limit !== 1'b1 ||
                    gen_set_steps_limit !== 1'b1 || gen_reset_steps !== 1'b1 ||
                    cyc != e.cyc) begin
                    errors++;
                    $display("FAIL load: got dt=%0d steps=%0d rdt=%0b sdl=%0b ssl=%0b rs=%0b cyc=%0d, required dt=%0d steps=%0d rdt=%0b strobes=1 cyc=%0d",
                             gen_dt_val, gen_steps_val, gen_reset_dt,
                             gen_set_dt_limit, gen_set_steps_limit,
                             gen_reset_steps, cyc, e.dt, e.steps, e.rdt, e.cyc);
                end
            end
        end else if (gen_set_dt_limit || gen_set_steps_limit ||
                     gen_reset_dt || gen_reset_steps) begin
            checks++;
            errors++;
            $display("FAIL stray_strobe: got strobes without gen_load at cyc=%0d, required 0", cyc);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic expect_load(input logic [31:0] dt, input logic [31:0] st,
                               input logic rdt);
        exp_t e;
        e.dt    = dt;
        e.steps = st;
        e.rdt   = rdt;
        e.cyc   = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic push(input logic [31:0] dt, input logic [31:0] st);
        seg_dt    = dt;
        seg_steps = st;
        seg_valid = 1'b1;
        tick();
        seg_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_done();
        gen_done = 1'b1;
        tick();
        gen_done = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic step_pulse();
        gen_step_stb = 1'b1;
        tick();
        gen_step_stb = 1'b0;
        exp_total++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        exp_total = 0;
    endtask

    initial begin
        reset        = 1'b1;
        seg_dt       = '0;
        seg_steps    = '0;
        seg_valid    = 1'b0;
        start        = 1'b0;
        flush        = 1'b0;
        abort_dt     = '0;
        gen_step_stb = 1'b0;
        gen_done     = 1'b0;
        gen_abort    = 1'b0;
        do_reset();

        chk("rst_seg_ready", seg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_segs_done", segs_done, 0);
        chk("rst_total", total_steps, 0);
        chk("rst_dt_val", gen_dt_val, 0);
        chk("rst_load", gen_load, 0);

        // Single segment, load one cycle after start.
        push(10, 3);
        expect_load(10, 3, 1'b1);
        do_start();
        chk("single_busy", busy, 1);
        tick(2);
        do_done();
        chk("single_segs", segs_done, 1);
        chk("single_wait_busy", busy, 1);
        do_flush();
        chk("single_flush_busy", busy, 0);

        // Three segments back to back.
        do_reset();
        push(20, 5);
        push(30, 6);
        push(40, 7);
        expect_load(20, 5, 1'b1);
        do_start();
        step_pulse();
        step_pulse();
        expect_load(30, 6, 1'b0);
        do_done();
        step_pulse();
        tick();
        expect_load(40, 7, 1'b0);
        do_done();
        tick(2);
        do_done();
        chk("three_segs", segs_done, 3);
        chk("three_wait_busy", busy, 1);
        chk("three_total", total_steps, exp_total);

        // Abort from WAIT_DATA.
        abort_dt  = 500;
        gen_abort = 1'b1;
        tick();
        gen_abort = 1'b0;
        chk("abort_busy", busy, 1);
        chk("abort_underrun", underrun, 1);
        chk("abort_dt_val", gen_dt_val, 500);
        step_pulse();
        step_pulse();
        chk("abort_total", total_steps, exp_total);
        tick(2);
        do_flush();
        chk("abort_flush_busy", busy, 0);
        chk("abort_flush_underrun", underrun, 1);

        // Start with empty FIFO does nothing.
        do_start();
        chk("empty_start_busy", busy, 0);
        chk("empty_start_underrun", underrun, 1);

        // Fill past DEPTH while idle.
        for (int i = 0; i < 4; i++) begin
            chk("fill_ready", seg_ready, 1);
            push(100 + i, i);
        end
        chk("full_ready", seg_ready, 0);
        push(200, 9);
        chk("full_ready2", seg_ready, 0);
        flush = 1'b1;
        start = 1'b1;
        tick();
        flush = 1'b0;
        start = 1'b0;
        chk("flush_start_busy", busy, 0);
        chk("flush_ready", seg_ready, 1);
        do_start();
        chk("flushed_empty_busy", busy, 0);

        // Segment arriving with abort stays queued.
        push(60, 8);
        expect_load(60, 8, 1'b1);
        do_start();
        chk("restart_underrun_clr", underrun, 0);
        tick(2);
        do_done();
        tick();
        seg_dt    = 70;
        seg_steps = 9;
        seg_valid = 1'b1;
        gen_abort = 1'b1;
        tick();
        seg_valid = 1'b0;
        chk("race_underrun", underrun, 1);
        chk("race_busy", busy, 1);
        push(71, 1);
        push(72, 1);
        chk("race_not_full", seg_ready, 1);
        push(73, 1);
        chk("race_retained_full", seg_ready, 0);
        tick();
        gen_abort = 1'b0;
        do_flush();
        chk("race_flush_busy", busy, 0);
        push(80, 11);
        expect_load(80, 11, 1'b1);
        do_start();
        chk("race_restart_underrun", underrun, 0);
        tick();

        // Reset during RUN with gen_done high drops the pending load.
        push(90, 1);
        tick();
        gen_done = 1'b1;
        reset    = 1'b1;
        tick();
        gen_done = 1'b0;
        reset    = 1'b0;
        exp_total = 0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_load", gen_load, 0);
        chk("mid_rst_segs", segs_done, 0);
        chk("mid_rst_total", total_steps, 0);
        chk("mid_rst_underrun", underrun, 0);
        chk("mid_rst_dt", gen_dt_val, 0);
        chk("mid_rst_steps", gen_steps_val, 0);
        chk("mid_rst_ready", seg_ready, 1);
        tick(3);

        chk("sb_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
